uart_prog_loader: RTL
=====================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT, default 87, SHALL set UART bit period in upg_clk_i cycles (10 MHz / 115200).
REQ-003 Parameter TIMEOUT_CLKS, default 1_000_000, SHALL set the idle gap in cycles that ends programming.
REQ-004 upg_clk_i  input  1  10 MHz programmer clock.
REQ-005 upg_rst_i  input  1  synchronous active-high reset.
REQ-006 upg_rx_i  input  1  asynchronous UART serial input, idle high.
REQ-007 upg_wen_o  output  1  one-cycle write strobe for the assembled word.
REQ-008 upg_adr_o  output  15  word address; bit 14 = 0 selects program ROM, 1 selects data RAM.
REQ-009 upg_dat_o  output  32  assembled word.
REQ-010 upg_done_o  output  1  sticky high when programming has finished.
REQ-011 upg_err_o  output  1  sticky framing/parity error flag.

Function
REQ-012 upg_rx_i SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, PARITY (only with UPG_PARITY_EN), and STOP.
REQ-014 IDLE SHALL move to START on a synchronized high-to-low edge, only while upg_done_o = 0.
REQ-015 START SHALL resample at CLKS_PER_BIT/2; if the line is high, it SHALL return to IDLE with no error (glitch); if low, it SHALL go to DATA.
REQ-016 DATA SHALL sample 8 bits, LSB first, each one CLKS_PER_BIT after the previous sample.
REQ-017 STOP SHALL sample one CLKS_PER_BIT later; low = framing error: byte dropped, upg_err_o set, return to IDLE.
REQ-018 Accepted bytes SHALL assemble little-endian: byte 0 into [7:0], ..., byte 3 into [31:24].
REQ-019 On the 4th accepted byte, upg_dat_o and upg_adr_o SHALL be valid and upg_wen_o high for exactly one cycle, on the cycle after the stop-bit sample.
REQ-020 upg_dat_o and upg_adr_o SHALL hold their values until the next write.
REQ-021 The address counter SHALL increment by 1 after each write, starting at 0.
REQ-022 A write at address 0x7FFF SHALL set upg_done_o on the same cycle as upg_wen_o; the counter SHALL not wrap to 0.
REQ-023 The idle counter SHALL reset on every accepted byte; it SHALL count only after at least one write has occurred.
REQ-024 If the idle count reaches TIMEOUT_CLKS, upg_done_o SHALL be set and any partial word (1-3 bytes) discarded without a write.
REQ-025 Once upg_done_o = 1, all further serial input SHALL be ignored and upg_wen_o SHALL stay 0 until reset.
REQ-026 A dropped byte SHALL not advance the byte counter; assembly SHALL resume with the next good byte.

Reset
REQ-027 On upg_rst_i high at a clock edge, the following SHALL be 0: FSM = IDLE, byte counter, bit counter, baud counter, idle counter, address counter, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o.
REQ-028 Reset mid-frame or mid-word SHALL discard all partial data; no write SHALL occur on or after the reset cycle.
REQ-029 Synchronizer flops SHALL reset to 1 (idle line).

Configuration
REQ-030 With macro UPG_PARITY_EN defined, an even-parity bit SHALL follow the data bits; a mismatch SHALL drop the byte and set upg_err_o.
REQ-031 Without UPG_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL not exist, and upg_err_o SHALL reflect framing errors only.

Verification
REQ-032 Send bytes 78 56 34 12 (8N1) -> one upg_wen_o pulse, upg_adr_o = 0x0000, upg_dat_o = 0x12345678.
REQ-033 Send 8 bytes, then idle for TIMEOUT_CLKS -> writes at addresses 0 and 1, then upg_done_o = 1, upg_err_o = 0.
REQ-034 Send a frame with stop bit = 0 inside a word -> byte dropped, upg_err_o = 1, next 4 good bytes form the word at the next address.
REQ-035 Pulse upg_rx_i low for 20 cycles -> no byte accepted, upg_err_o = 0.
REQ-036 Preload the address counter to 0x7FFF (by sending 32767 words) and send one more word -> write at 0x7FFF, upg_done_o = 1 in the same cycle, further bytes ignored.
REQ-037 Assert upg_rst_i after 2 bytes, then send 4 bytes -> one write at 0x0000 containing only the post-reset bytes.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART (8N1, or 8E1 with UPG_PARITY_EN) to 32-bit word writer for program/data memory preload.
// Write strobe one cycle after the 4th stop-bit sample; no backpressure; inactive once done.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        upg_rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int BW   = $clog2(CLKS_PER_BIT + 1);
  localparam int IW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_END = BW'(HALF - 1);
  localparam logic [IW-1:0] IDLE_END = IW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UPG_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic [14:0]   adr_cnt;
  logic [7:0]    rx_shift;
  logic [23:0]   word;
  logic          wrote;

  logic fall, bit_tick, half_tick;
  logic baud_clr, shift_en, byte_ok, frame_err;

  assign fall      = rx_prev & ~rx_sync;
  assign bit_tick  = (baud_cnt == BIT_END);
  assign half_tick = (baud_cnt == HALF_END);

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    baud_clr  = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        baud_clr = 1'b1;
        if (fall && !upg_done_o) state_nxt = START;
      end
      START: if (half_tick) begin
        baud_clr  = 1'b1;
        state_nxt = rx_sync ? IDLE : DATA;
      end
      DATA: if (bit_tick) begin
        baud_clr = 1'b1;
        shift_en = 1'b1;
`ifdef UPG_PARITY_EN
        if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
        if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef UPG_PARITY_EN
      // Even parity: the parity bit equals the XOR of the data bits.
      PARITY: if (bit_tick) begin
        baud_clr = 1'b1;
        if (rx_sync != ^rx_shift) begin
          frame_err = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
`endif
      STOP: if (bit_tick) begin
        baud_clr  = 1'b1;
        state_nxt = IDLE;
        byte_ok   = rx_sync;
        frame_err = ~rx_sync;
      end
      default: state_nxt = IDLE;
    endcase
    if (upg_done_o) begin
      state_nxt = IDLE;
      byte_ok   = 1'b0;
      frame_err = 1'b0;
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      adr_cnt    <= '0;
      rx_shift   <= '0;
      word       <= '0;
      wrote      <= 1'b0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
    end else begin
      rx_meta   <= upg_rx_i;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      upg_wen_o <= 1'b0;
      baud_cnt  <= baud_clr ? '0 : baud_cnt + 1'b1;

      if (state == IDLE) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (frame_err) upg_err_o <= 1'b1;

      // Bytes shift in from the top so byte 0 ends up in the low lane.
      if (byte_ok) begin
        idle_cnt <= '0;
        if (byte_cnt != 2'd3) begin
          word     <= {rx_shift, word[23:8]};
          byte_cnt <= byte_cnt + 1'b1;
        end else begin
          upg_wen_o <= 1'b1;
          upg_dat_o <= {rx_shift, word};
          upg_adr_o <= adr_cnt;
          byte_cnt  <= '0;
          wrote     <= 1'b1;
          if (adr_cnt == 15'h7FFF) upg_done_o <= 1'b1;
          else                     adr_cnt    <= adr_cnt + 1'b1;
        end
      end else if (wrote && !upg_done_o) begin
        if (idle_cnt == IDLE_END) begin
          upg_done_o <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
